r4u2_one_ctrl: RTL and testbench
================================

# r4u2_one_ctrl

Frame controller for the stage-one buffer of pipeline FFT radix-4 unit 2. It accepts 64-sample block-floating-point frames from the upstream stage and writes them linearly into the 64-entry stage-one RAM. It then reads them back in radix-4 stride order (groups of 4 at stride 16) to feed the downstream butterfly. It also reports the frame's maximum exponent, which downstream uses for block-exponent alignment.

## Interface
- DW, 2*`MAN_WIDTH+`EXP_WIDTH: sample width, packed {re, im, exp}
- EW, `EXP_WIDTH: exponent width, which is the low EW bits of each sample
- clk_sys  in  1  system clock; all logic on the rising edge
- rst_sys  in  1  reset, asynchronous and active-high
- in_valid  in  1  upstream sample valid
- in_sop  in  1  marks the first sample of a frame; qualified by in_valid
- in_data  in  DW  upstream sample
- in_ready  out  1  controller accepts a sample this cycle
- ram_wr_en  out  1  RAM write enable, active low
- ram_wr_addr  out  6  RAM write address
- ram_wr_data  out  DW  RAM write data, equal to in_data
- ram_rd_addr  out  6  RAM read address, registered
- ram_rd_data  in  DW  RAM read data, valid one cycle after ram_rd_addr
- out_valid  out  1  downstream sample valid
- out_data  out  DW  downstream sample, equal to ram_rd_data
- out_sop  out  1  first output sample of a frame
- out_eop  out  1  last output sample of a frame
- out_idx  out  2  position of the sample within its 4-sample butterfly group
- out_exp_max  out  EW  unsigned maximum exponent of the current output frame

## Operation
- States are IDLE, FILL and DRAIN. Reset enters IDLE with cnt=0.
- A sample is accepted when in_valid and in_ready are both 1. in_ready is 1 in IDLE and FILL, and 0 in DRAIN.
- IDLE:
  - An accepted sample with in_sop=1 is written to address 0, sets cnt=1, loads exp_acc with its exponent, and moves to FILL.
  - An accepted sample with in_sop=0 is dropped: no write occurs.
- FILL:
  - Each accepted sample is written to address cnt, updates exp_acc to max(exp_acc, exp), and increments cnt.
  - in_valid gaps are allowed; cnt holds during a gap.
  - An accepted in_sop=1 sample mid-frame aborts the partial frame. It is written to address 0, and cnt and exp_acc restart as in IDLE.
  - The 64th accepted sample (cnt=63) latches out_exp_max from max(exp_acc, exp), clears cnt, and moves to DRAIN.
- ram_wr_en is low only in a cycle where a sample is written. ram_wr_addr equals the current write address, and ram_wr_data equals in_data, both combinational from the current-cycle inputs.
- DRAIN:
  - Runs for exactly 64 cycles; d=0..63 is the cycle index.
  - ram_rd_addr = {d[1:0], d[5:2]}, giving the sequence 0,16,32,48,1,17,...,63.
  - After d=63 the state returns to IDLE.
  - in_valid is ignored throughout DRAIN.
- Output pipeline: out_valid, out_sop, out_eop and out_idx are registered copies of the read strobe, with d==0, d==63 and d[1:0] respectively. They therefore align with ram_rd_data one cycle later.
- out_exp_max holds its value until the next frame completes, so it stays stable during the whole drain and afterwards.

## Timing
- Let t be the cycle in which the 64th sample is accepted.
  - DRAIN occupies cycles t+1..t+64.
  - out_valid is high in cycles t+2..t+65, with out_sop at t+2 and out_eop at t+65.
  - in_ready returns to 1 at cycle t+65. A write in t+65 cannot collide with the read of t+64, because that read has already been issued.
- The write of cycle t is committed at the edge ending t, and the first read is issued in t+1. There is no read-during-write hazard.
- Reset values: in_ready=1 once the state reaches IDLE (0 while rst_sys is asserted), ram_wr_en=1, ram_rd_addr=0, out_valid=0, out_sop=0, out_eop=0, out_idx=0, out_exp_max=0.
- Asserting rst_sys mid-FILL or mid-DRAIN abandons the frame immediately and suppresses all pending out_valid.
- Throughput is one frame per 128 cycles when the input has no gaps.

## Test plan
- Reset: assert rst_sys mid-cycle, then release. Required: all outputs at their reset values, in_ready=1 the cycle after release, and no RAM write.
- Single frame: send sample i with re=i, im=0, exp=0, sop on i=0, gap-free. Required: out_data re sequence 0,16,32,48,1,17,33,49,...,15,31,47,63. out_idx cycles 0,1,2,3. out_sop on the first output and out_eop on the last. The first out_valid arrives 2 cycles after the last accept.
- Exponent: in a 64-sample frame, all exponents are 3 except sample 37, which is 9. Required: out_exp_max=9 during the drain, held until the next frame completes.
- Drop and restart: 5 samples with in_sop=0 while IDLE, then a frame in which sop is reasserted at sample 20, followed by 64 further samples. Required: the 5 samples are never written. The output is exactly the last 64 samples in stride order, with no stale data.
- Backpressure and gaps: random in_valid gaps during FILL, with in_valid held high during DRAIN. Required: in_ready=0 for exactly 64 cycles, no RAM write during DRAIN, and output order unchanged.
- Back-to-back frames: two frames where the second frame's sop is presented as soon as in_ready returns. Required: the second frame's first write lands in the cycle of the first frame's out_eop, and both frames are output correctly.

Source files
------------

// File: rtl/r4u2_one_ctrl_if.sv
// Sample, RAM-port and output bus of the radix-4 unit 2 stage-one buffer controller.
// The controller side uses the master modport; upstream, RAM and downstream use the slave modport.
`ifndef MAN_WIDTH
`define MAN_WIDTH 8
`endif
`ifndef EXP_WIDTH
`define EXP_WIDTH 4
`endif

interface r4u2_one_ctrl_if #(
  parameter int DW = 2*`MAN_WIDTH+`EXP_WIDTH,
  parameter int EW = `EXP_WIDTH
);
  logic          in_valid;
  logic          in_sop;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          ram_wr_en;
  logic [5:0]    ram_wr_addr;
  logic [DW-1:0] ram_wr_data;
  logic [5:0]    ram_rd_addr;
  logic [DW-1:0] ram_rd_data;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_sop;
  logic          out_eop;
  logic [1:0]    out_idx;
  logic [EW-1:0] out_exp_max;

  modport master (
    input  in_valid, in_sop, in_data, ram_rd_data,
    output in_ready, ram_wr_en, ram_wr_addr, ram_wr_data, ram_rd_addr,
           out_valid, out_data, out_sop, out_eop, out_idx, out_exp_max
  );

  modport slave (
    output in_valid, in_sop, in_data, ram_rd_data,
    input  in_ready, ram_wr_en, ram_wr_addr, ram_wr_data, ram_rd_addr,
           out_valid, out_data, out_sop, out_eop, out_idx, out_exp_max
  );
endinterface

// File: rtl/r4u2_one_ctrl.sv
// Stage-one frame controller: linear 64-sample fill, radix-4 stride-16 drain,
// and block-exponent maximum tracking.
`ifndef MAN_WIDTH
`define MAN_WIDTH 8
`endif
`ifndef EXP_WIDTH
`define EXP_WIDTH 4
`endif

module r4u2_one_ctrl #(
  parameter int DW = 2*`MAN_WIDTH+`EXP_WIDTH,
  parameter int EW = `EXP_WIDTH
) (
  input  logic            clk_sys,
  input  logic            rst_sys,
  r4u2_one_ctrl_if.master bus
);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_DRAIN} state_t;

  state_t        state_reg, state_next;
  logic [5:0]    cnt_reg, cnt_next;
  logic [EW-1:0] exp_acc_reg, exp_acc_next;
  logic [EW-1:0] exp_max_reg, exp_max_next;
  logic [5:0]    rd_addr_reg, rd_addr_next;
  logic          out_valid_reg, out_sop_reg, out_eop_reg;
  logic [1:0]    out_idx_reg;

  logic [DW-1:0] sample;
  logic [EW-1:0] in_exp;
  logic [EW-1:0] exp_merged;
  logic          in_ready_c;
  logic          accept;
  logic          wr_c;
  logic [5:0]    wr_addr_c;
  logic          rd_c;

  assign sample     = bus.in_data;
  assign in_exp     = sample[EW-1:0];
  assign exp_merged = (in_exp > exp_acc_reg) ? in_exp : exp_acc_reg;
  // Held low during reset so nothing upstream believes a sample was taken.
  assign in_ready_c = (state_reg != S_DRAIN) && !rst_sys;
  assign accept     = bus.in_valid && in_ready_c;

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    exp_acc_next = exp_acc_reg;
    exp_max_next = exp_max_reg;
    wr_c         = 1'b0;
    wr_addr_c    = cnt_reg;
    rd_c         = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (accept && bus.in_sop) begin
          wr_c         = 1'b1;
          wr_addr_c    = 6'd0;
          cnt_next     = 6'd1;
          exp_acc_next = in_exp;
          state_next   = S_FILL;
        end
      end
      S_FILL: begin
        if (accept) begin
          wr_c = 1'b1;
          if (bus.in_sop) begin
            // A new sop abandons the partial frame and restarts at address 0.
            wr_addr_c    = 6'd0;
            cnt_next     = 6'd1;
            exp_acc_next = in_exp;
          end else if (cnt_reg == 6'd63) begin
            exp_max_next = exp_merged;
            cnt_next     = 6'd0;
            state_next   = S_DRAIN;
          end else begin
            cnt_next     = cnt_reg + 6'd1;
            exp_acc_next = exp_merged;
          end
        end
      end
      S_DRAIN: begin
        rd_c     = 1'b1;
        cnt_next = cnt_reg + 6'd1;
        if (cnt_reg == 6'd63) begin
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
    // The read address register runs one step ahead so each drain cycle presents its own address.
    rd_addr_next = (state_next == S_DRAIN) ? {cnt_next[1:0], cnt_next[5:2]} : 6'd0;
  end

  always_ff @(posedge clk_sys or posedge rst_sys) begin
    if (rst_sys) begin
      state_reg     <= S_IDLE;
      cnt_reg       <= 6'd0;
      exp_acc_reg   <= '0;
      exp_max_reg   <= '0;
      rd_addr_reg   <= 6'd0;
      out_valid_reg <= 1'b0;
      out_sop_reg   <= 1'b0;
      out_eop_reg   <= 1'b0;
      out_idx_reg   <= 2'd0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      exp_acc_reg   <= exp_acc_next;
      exp_max_reg   <= exp_max_next;
      rd_addr_reg   <= rd_addr_next;
      out_valid_reg <= rd_c;
      out_sop_reg   <= rd_c && (cnt_reg == 6'd0);
      out_eop_reg   <= rd_c && (cnt_reg == 6'd63);
      out_idx_reg   <= rd_c ? cnt_reg[1:0] : 2'd0;
    end
  end

  assign bus.in_ready    = in_ready_c;
  assign bus.ram_wr_en   = ~wr_c;
  assign bus.ram_wr_addr = wr_addr_c;
  assign bus.ram_wr_data = sample;
  assign bus.ram_rd_addr = rd_addr_reg;
  assign bus.out_valid   = out_valid_reg;
  assign bus.out_data    = bus.ram_rd_data;
  assign bus.out_sop     = out_sop_reg;
  assign bus.out_eop     = out_eop_reg;
  assign bus.out_idx     = out_idx_reg;
  assign bus.out_exp_max = exp_max_reg;

endmodule

// File: tb/tb_r4u2_one_ctrl.sv
// Directed testbench for r4u2_one_ctrl with a behavioural 64-entry RAM
// and output/write monitors.
`ifndef MAN_WIDTH
`define MAN_WIDTH 8
`endif
`ifndef EXP_WIDTH
`define EXP_WIDTH 4
`endif

module tb_r4u2_one_ctrl;
  localparam int MW = `MAN_WIDTH;
  localparam int EW = `EXP_WIDTH;
  localparam int DW = 2*MW+EW;

  logic clk_sys = 1'b0;
  logic rst_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  r4u2_one_ctrl_if #(.DW(DW), .EW(EW)) bus ();
  r4u2_one_ctrl #(.DW(DW), .EW(EW)) dut (.clk_sys(clk_sys), .rst_sys(rst_sys), .bus(bus));

  logic [DW-1:0] mem [64];
  logic [DW-1:0] rd_q;
  always @(posedge clk_sys) begin
    if (!bus.ram_wr_en) mem[bus.ram_wr_addr] <= bus.ram_wr_data;
    rd_q <= mem[bus.ram_rd_addr];
  end
  assign bus.ram_rd_data = rd_q;

  typedef struct {
    logic [DW-1:0] data;
    logic [1:0]    idx;
    logic          sop;
    logic          eop;
    logic [EW-1:0] emax;
    int            c;
  } out_t;

  typedef struct {
    logic [DW-1:0] data;
    logic [5:0]    addr;
    int            c;
  } wr_t;

  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  out_t out_q[$];
  wr_t  wr_q[$];
  int   wr_cnt, wr_drain_cnt, ready_low_cnt, last_acc_cyc;

  always @(posedge clk_sys) cyc <= cyc + 1;

  always @(negedge clk_sys) begin
    out_t o;
    wr_t  w;
    if (bus.out_valid) begin
      o.data = bus.out_data; o.idx = bus.out_idx; o.sop = bus.out_sop;
      o.eop = bus.out_eop; o.emax = bus.out_exp_max; o.c = cyc;
      out_q.push_back(o);
    end
    if (!bus.ram_wr_en) begin
      w.data = bus.ram_wr_data; w.addr = bus.ram_wr_addr; w.c = cyc;
      wr_q.push_back(w);
      wr_cnt++;
      if (!bus.in_ready) wr_drain_cnt++;
    end
    if (!bus.in_ready && !rst_sys) ready_low_cnt++;
    if (bus.in_valid && bus.in_ready) last_acc_cyc = cyc;
  end

  function automatic logic [DW-1:0] mk(input int re, input int tag, input int e);
    logic [DW-1:0] v;
    v = {MW'(re), MW'(tag), EW'(e)};
    return v;
  endfunction

  function automatic int stride_addr(input int d);
    return (d % 4) * 16 + d / 4;
  endfunction

  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic begin_test();
    out_q.delete();
    wr_q.delete();
    wr_cnt = 0;
    wr_drain_cnt = 0;
    ready_low_cnt = 0;
  endtask

  task automatic send_samples(input int tag, input int first, input int n, input bit sop_first,
                              input int e_def, input int sp_idx, input int sp_exp,
                              input int gap_pct, input bit hold_after);
    for (int i = first; i < first + n; i++) begin
      while (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
        bus.in_valid = 1'b0;
        bus.in_sop   = 1'b0;
        step();
      end
      bus.in_valid = 1'b1;
      bus.in_sop   = sop_first && (i == first);
      bus.in_data  = mk(i, tag, (i == sp_idx) ? sp_exp : e_def);
      step();
    end
    bus.in_valid = hold_after;
    bus.in_sop   = 1'b0;
    bus.in_data  = mk(0, 8'hEE, 0);
  endtask

  task automatic wait_outputs(input int n);
    for (int k = 0; k < 400 && out_q.size() < n; k++) step();
  endtask

  task automatic test_reset();
    bus.in_valid = 1'b0; bus.in_sop = 1'b0; bus.in_data = '0;
    step(); step();
    #2;
    rst_sys = 1'b1;
    bus.in_valid = 1'b1; bus.in_sop = 1'b1; bus.in_data = mk(0, 15, 0);
    begin_test();
    @(negedge clk_sys);
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got=%b exp=0", bus.in_ready); end
    checks++; if (bus.ram_wr_en !== 1'b1) begin errors++; $display("FAIL rst_wr_en got=%b exp=1", bus.ram_wr_en); end
    checks++; if (bus.ram_rd_addr !== 6'd0) begin errors++; $display("FAIL rst_rd_addr got=%0d exp=0", bus.ram_rd_addr); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got=%b exp=0", bus.out_valid); end
    checks++; if (bus.out_sop !== 1'b0) begin errors++; $display("FAIL rst_out_sop got=%b exp=0", bus.out_sop); end
    checks++; if (bus.out_eop !== 1'b0) begin errors++; $display("FAIL rst_out_eop got=%b exp=0", bus.out_eop); end
    checks++; if (bus.out_idx !== 2'd0) begin errors++; $display("FAIL rst_out_idx got=%0d exp=0", bus.out_idx); end
    checks++; if (bus.out_exp_max !== '0) begin errors++; $display("FAIL rst_exp_max got=%0d exp=0", bus.out_exp_max); end
    repeat (3) step();
    rst_sys = 1'b0;
    bus.in_valid = 1'b0; bus.in_sop = 1'b0;
    @(negedge clk_sys);
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready got=%b exp=1", bus.in_ready); end
    checks++; if (wr_cnt !== 0) begin errors++; $display("FAIL rst_no_write got=%0d writes exp=0", wr_cnt); end
    step();
    $display("test_reset done");
  endtask

  task automatic test_single_frame();
    begin_test();
    send_samples(1, 0, 64, 1'b1, 0, -1, 0, 0, 1'b0);
    wait_outputs(64);
    checks++; if (out_q.size() !== 64) begin errors++; $display("FAIL single_count got=%0d exp=64", out_q.size()); end
    for (int d = 0; d < 64 && d < out_q.size(); d++) begin
      checks++;
      if (out_q[d].data !== mk(stride_addr(d), 1, 0)) begin
        errors++; $display("FAIL single_data d=%0d got=%h exp=%h", d, out_q[d].data, mk(stride_addr(d), 1, 0));
      end
      checks++;
      if (out_q[d].idx !== 2'(d % 4)) begin
        errors++; $display("FAIL single_idx d=%0d got=%0d exp=%0d", d, out_q[d].idx, d % 4);
      end
      checks++;
      if (out_q[d].sop !== (d == 0) || out_q[d].eop !== (d == 63)) begin
        errors++; $display("FAIL single_sop_eop d=%0d got=%b%b exp=%b%b", d, out_q[d].sop, out_q[d].eop, d == 0, d == 63);
      end
    end
    if (out_q.size() == 64) begin
      checks++;
      if (out_q[0].c - last_acc_cyc !== 2) begin
        errors++; $display("FAIL single_latency got=%0d exp=2", out_q[0].c - last_acc_cyc);
      end
      checks++;
      if (out_q[63].c - out_q[0].c !== 63) begin
        errors++; $display("FAIL single_contiguous got=%0d exp=63", out_q[63].c - out_q[0].c);
      end
    end
    $display("test_single_frame done: %0d outputs", out_q.size());
  endtask

  task automatic test_exponent();
    int bad;
    begin_test();
    send_samples(2, 0, 64, 1'b1, 3, 37, 9, 0, 1'b0);
    wait_outputs(64);
    bad = 0;
    foreach (out_q[k]) if (out_q[k].emax !== EW'(9)) bad++;
    checks++; if (out_q.size() !== 64 || bad !== 0) begin errors++; $display("FAIL exp_drain got=%0d bad of %0d exp=0 bad of 64", bad, out_q.size()); end
    repeat (5) step();
    checks++; if (bus.out_exp_max !== EW'(9)) begin errors++; $display("FAIL exp_hold_idle got=%0d exp=9", bus.out_exp_max); end
    begin_test();
    send_samples(3, 0, 63, 1'b1, 5, -1, 0, 0, 1'b0);
    checks++; if (bus.out_exp_max !== EW'(9)) begin errors++; $display("FAIL exp_hold_fill got=%0d exp=9", bus.out_exp_max); end
    send_samples(3, 63, 1, 1'b0, 5, -1, 0, 0, 1'b0);
    checks++; if (bus.out_exp_max !== EW'(5)) begin errors++; $display("FAIL exp_update got=%0d exp=5", bus.out_exp_max); end
    wait_outputs(64);
    $display("test_exponent done: exp_max=%0d", bus.out_exp_max);
  endtask

  task automatic test_drop_restart();
    int bad_drop, bad_data;
    begin_test();
    send_samples(8'hA5, 0, 5, 1'b0, 0, -1, 0, 0, 1'b0);
    send_samples(8'h21, 0, 20, 1'b1, 0, -1, 0, 0, 1'b0);
    send_samples(8'h22, 0, 64, 1'b1, 0, -1, 0, 0, 1'b0);
    wait_outputs(64);
    bad_drop = 0;
    foreach (wr_q[k]) if (wr_q[k].data[EW +: MW] === MW'(8'hA5)) bad_drop++;
    checks++; if (bad_drop !== 0) begin errors++; $display("FAIL drop_written got=%0d exp=0", bad_drop); end
    checks++; if (wr_cnt !== 84) begin errors++; $display("FAIL drop_wr_count got=%0d exp=84", wr_cnt); end
    checks++; if (out_q.size() !== 64) begin errors++; $display("FAIL drop_out_count got=%0d exp=64", out_q.size()); end
    bad_data = 0;
    for (int d = 0; d < out_q.size(); d++) if (out_q[d].data !== mk(stride_addr(d), 8'h22, 0)) bad_data++;
    checks++; if (bad_data !== 0) begin errors++; $display("FAIL drop_out_data got=%0d wrong exp=0", bad_data); end
    $display("test_drop_restart done: %0d writes", wr_cnt);
  endtask

  task automatic test_backpressure();
    int bad_data;
    begin_test();
    send_samples(4, 0, 64, 1'b1, 0, -1, 0, 30, 1'b1);
    wait_outputs(64);
    repeat (3) step();
    bus.in_valid = 1'b0;
    step();
    checks++; if (ready_low_cnt !== 64) begin errors++; $display("FAIL bp_ready_low got=%0d exp=64", ready_low_cnt); end
    checks++; if (wr_drain_cnt !== 0) begin errors++; $display("FAIL bp_drain_write got=%0d exp=0", wr_drain_cnt); end
    checks++; if (wr_cnt !== 64) begin errors++; $display("FAIL bp_wr_count got=%0d exp=64", wr_cnt); end
    checks++; if (out_q.size() !== 64) begin errors++; $display("FAIL bp_out_count got=%0d exp=64", out_q.size()); end
    bad_data = 0;
    for (int d = 0; d < out_q.size(); d++) if (out_q[d].data !== mk(stride_addr(d), 4, 0)) bad_data++;
    checks++; if (bad_data !== 0) begin errors++; $display("FAIL bp_out_data got=%0d wrong exp=0", bad_data); end
    $display("test_backpressure done: ready low %0d cycles", ready_low_cnt);
  endtask

  task automatic test_back_to_back();
    bit accepted;
    int first_wr_c, bad_data;
    begin_test();
    send_samples(5, 0, 64, 1'b1, 0, -1, 0, 0, 1'b0);
    bus.in_valid = 1'b1; bus.in_sop = 1'b1; bus.in_data = mk(0, 6, 0);
    accepted = 1'b0;
    for (int k = 0; k < 100 && !accepted; k++) begin
      if (bus.in_ready) accepted = 1'b1;
      step();
    end
    checks++; if (accepted !== 1'b1) begin errors++; $display("FAIL b2b_ready_timeout got=0 exp=1"); end
    send_samples(6, 1, 63, 1'b0, 0, -1, 0, 0, 1'b0);
    wait_outputs(128);
    checks++; if (out_q.size() !== 128) begin errors++; $display("FAIL b2b_out_count got=%0d exp=128", out_q.size()); end
    first_wr_c = -1;
    foreach (wr_q[k]) if (first_wr_c < 0 && wr_q[k].data === mk(0, 6, 0)) first_wr_c = wr_q[k].c;
    if (out_q.size() >= 64) begin
      checks++;
      if (out_q[63].eop !== 1'b1 || first_wr_c !== out_q[63].c) begin
        errors++; $display("FAIL b2b_first_write got=cyc %0d exp=cyc %0d (eop=%b)", first_wr_c, out_q[63].c, out_q[63].eop);
      end
    end
    bad_data = 0;
    for (int d = 0; d < out_q.size(); d++) if (out_q[d].data !== mk(stride_addr(d % 64), (d < 64) ? 5 : 6, 0)) bad_data++;
    checks++; if (bad_data !== 0) begin errors++; $display("FAIL b2b_out_data got=%0d wrong exp=0", bad_data); end
    $display("test_back_to_back done: %0d outputs", out_q.size());
  endtask

  task automatic test_reset_midframe();
    int bad_data;
    begin_test();
    send_samples(7, 0, 10, 1'b1, 0, -1, 0, 0, 1'b0);
    #2; rst_sys = 1'b1;
    @(negedge clk_sys);
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL midfill_ready got=%b exp=0", bus.in_ready); end
    step();
    rst_sys = 1'b0;
    begin_test();
    send_samples(9, 0, 64, 1'b1, 0, -1, 0, 0, 1'b0);
    wait_outputs(64);
    bad_data = 0;
    for (int d = 0; d < out_q.size(); d++) if (out_q[d].data !== mk(stride_addr(d), 9, 0)) bad_data++;
    checks++; if (out_q.size() !== 64 || bad_data !== 0) begin errors++; $display("FAIL midfill_frame got=%0d outputs %0d wrong exp=64 outputs 0 wrong", out_q.size(), bad_data); end
    begin_test();
    send_samples(10, 0, 64, 1'b1, 2, -1, 0, 0, 1'b0);
    repeat (10) step();
    #2; rst_sys = 1'b1;
    @(negedge clk_sys);
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL middrain_valid got=%b exp=0", bus.out_valid); end
    checks++; if (bus.out_exp_max !== '0) begin errors++; $display("FAIL middrain_exp got=%0d exp=0", bus.out_exp_max); end
    step();
    rst_sys = 1'b0;
    out_q.delete();
    repeat (80) step();
    checks++; if (out_q.size() !== 0) begin errors++; $display("FAIL middrain_suppress got=%0d outputs exp=0", out_q.size()); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL middrain_idle got=%b exp=1", bus.in_ready); end
    $display("test_reset_midframe done");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_frame();
    test_exponent();
    test_drop_restart();
    test_backpressure();
    test_back_to_back();
    test_reset_midframe();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
